// File: rtl/sos_multi_dist_calc.sv
// Purpose: fires one impulse request, then times the echo on NUM_CH microphones using
//   windowed-energy onset detection. A per-channel delay is reported only once
//   CONFIRM_COUNT consecutive attempts agree within TOL samples of a running reference.
// Latency: one attempt takes the impulse handshake, up to MAX_DELAY step_in strobes,
//   one evaluation cycle and RETRY_CYCLES idle clocks before the next attempt.
// Backpressure: none on the sample path. The impulse generator is handshaked with
//   impulse_start_out/impulse_done_in, and trigger_in is ignored while busy_out is high.
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   step_in                 one-cycle sample strobe, used only while listening
//   trigger_in              starts a measurement from idle
//   mic_in                  NUM_CH signed 16-bit samples, channel c at [16c+15:16c]
//   impulse_start_out       one-cycle impulse request
//   impulse_done_in         impulse emitted, defines sample index 0
//   delay_out               confirmed delay per channel, DELAY_W bits each
//   delay_valid_out         per-channel confirmed flag
//   busy_out                high outside idle
//   done_out                one-cycle pulse at end of measurement
//   fail_out                last measurement ran out of attempts
module sos_multi_dist_calc #(
  parameter int NUM_CH        = 2,
  parameter int WINDOW_SIZE   = 16,
  parameter int MAX_DELAY     = 512,
  parameter int DELAY_W       = 12,
  parameter int THRESH_SHIFT  = 1,
  parameter int MIN_ENERGY    = 1024,
  parameter int CONFIRM_COUNT = 3,
  parameter int TOL           = 1,
  parameter int RETRY_CYCLES  = 60_000_000,
  parameter int MAX_ATTEMPTS  = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      step_in,
  input  logic                      trigger_in,
  input  logic [16*NUM_CH-1:0]      mic_in,
  output logic                      impulse_start_out,
  input  logic                      impulse_done_in,
  output logic [DELAY_W*NUM_CH-1:0] delay_out,
  output logic [NUM_CH-1:0]         delay_valid_out,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      fail_out
);

  localparam int WIN_W = $clog2(WINDOW_SIZE);
  localparam int CUR_W = 16 + WIN_W;            // a full window of 32767s cannot wrap
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int RET_W = $clog2(RETRY_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE, S_WAIT_IMP, S_LISTEN, S_EVAL, S_RETRY, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DELAY_W-1:0]   k_q, k_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [ATT_W-1:0]     att_q, att_d;
  logic [RET_W-1:0]     ret_q, ret_d;
  logic [CUR_W-1:0]     cur_q [NUM_CH];
  logic [CUR_W-1:0]     cur_d [NUM_CH];
  logic [CUR_W-1:0]     prev_q [NUM_CH];
  logic [CUR_W-1:0]     prev_d [NUM_CH];
  logic [CUR_W-1:0]     pp_q [NUM_CH];
  logic [CUR_W-1:0]     pp_d [NUM_CH];
  logic [DELAY_W-1:0]   meas_q [NUM_CH];
  logic [DELAY_W-1:0]   meas_d [NUM_CH];
  logic [DELAY_W-1:0]   ref_q [NUM_CH];
  logic [DELAY_W-1:0]   ref_d [NUM_CH];
  logic [DELAY_W-1:0]   dly_q [NUM_CH];
  logic [DELAY_W-1:0]   dly_d [NUM_CH];
  // Run length never exceeds the attempt count, so it shares that width.
  logic [ATT_W-1:0]     run_q [NUM_CH];
  logic [ATT_W-1:0]     run_d [NUM_CH];
  logic [NUM_CH-1:0]    hit_q, hit_d;
  logic [NUM_CH-1:0]    vld_q, vld_d;
  logic                 fail_q, fail_d;
  logic                 done_q, done_d;

  // Magnitude with -32768 clamped so it still fits 15 bits of magnitude.
  function automatic logic [15:0] abs_sat(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    else if (x[15])    return ~x + 16'd1;
    else               return x;
  endfunction

  always_comb begin : next_c
    logic [15:0]        mag;
    logic [CUR_W-1:0]   sum;
    logic [CUR_W:0]     thr;
    logic               onset;
    logic [DELAY_W-1:0] diff;

    state_d = state_q;
    k_d     = k_q;
    win_d   = win_q;
    att_d   = att_q;
    ret_d   = ret_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    pp_d    = pp_q;
    meas_d  = meas_q;
    ref_d   = ref_q;
    dly_d   = dly_q;
    run_d   = run_q;
    hit_d   = hit_q;
    vld_d   = vld_q;
    fail_d  = fail_q;
    done_d  = 1'b0;
    mag     = '0;
    sum     = '0;
    thr     = '0;
    onset   = 1'b0;
    diff    = '0;

    case (state_q)
      S_IDLE: begin
        if (trigger_in) begin
          vld_d  = '0;
          fail_d = 1'b0;
          att_d  = '0;
          for (int c = 0; c < NUM_CH; c++) run_d[c] = '0;
          state_d = S_FIRE;
        end
      end

      S_FIRE: begin
        att_d   = att_q + 1'b1;
        state_d = S_WAIT_IMP;
      end

      S_WAIT_IMP: begin
        if (impulse_done_in) begin
          k_d   = '0;
          win_d = '0;
          hit_d = '0;
          // All-ones history blocks detection until two real windows exist.
          for (int c = 0; c < NUM_CH; c++) begin
            cur_d[c]  = '0;
            prev_d[c] = '1;
            pp_d[c]   = '1;
          end
          state_d = S_LISTEN;
        end
      end

      S_LISTEN: begin
        if (step_in) begin
          k_d   = k_q + 1'b1;
          win_d = win_q + 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            mag      = abs_sat(mic_in[16*c +: 16]);
            sum      = cur_q[c] + CUR_W'(mag);
            cur_d[c] = sum;
            if (win_q == WIN_W'(WINDOW_SIZE - 1)) begin
              if (!hit_q[c]) begin
                thr   = {1'b0, pp_q[c]} + ({1'b0, pp_q[c]} >> THRESH_SHIFT);
                onset = ({1'b0, sum} > {1'b0, prev_q[c]}) &&
                        ({1'b0, sum} > thr) &&
                        ({1'b0, sum} >= (CUR_W+1)'(MIN_ENERGY));
                if (onset) begin
                  hit_d[c]  = 1'b1;
                  meas_d[c] = k_q - DELAY_W'(WINDOW_SIZE - 1);
                end
              end
              pp_d[c]   = prev_q[c];
              prev_d[c] = sum;
              cur_d[c]  = '0;
            end
          end
          if ((&hit_d) || (k_q == DELAY_W'(MAX_DELAY - 1))) state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (!hit_q[c]) begin
            run_d[c] = '0;
          end else begin
            diff = (meas_q[c] >= ref_q[c]) ? (meas_q[c] - ref_q[c]) : (ref_q[c] - meas_q[c]);
            if ((run_q[c] == '0) || (diff > DELAY_W'(TOL))) begin
              ref_d[c] = meas_q[c];
              run_d[c] = ATT_W'(1);
              if (CONFIRM_COUNT == 1) begin
                dly_d[c] = meas_q[c];
                vld_d[c] = 1'b1;
              end
            end else begin
              run_d[c] = run_q[c] + 1'b1;
              if (run_d[c] == ATT_W'(CONFIRM_COUNT)) begin
                dly_d[c] = ref_q[c];
                vld_d[c] = 1'b1;
              end
            end
          end
        end
        if (&vld_d) begin
          state_d = S_DONE;
        end else if (att_q == ATT_W'(MAX_ATTEMPTS)) begin
          fail_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          ret_d   = '0;
          state_d = S_RETRY;
        end
      end

      S_RETRY: begin
        if (ret_q == RET_W'(RETRY_CYCLES - 1)) state_d = S_FIRE;
        else                                   ret_d   = ret_q + 1'b1;
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      win_q   <= '0;
      att_q   <= '0;
      ret_q   <= '0;
      hit_q   <= '0;
      vld_q   <= '0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cur_q[c]  <= '0;
        prev_q[c] <= '0;
        pp_q[c]   <= '0;
        meas_q[c] <= '0;
        ref_q[c]  <= '0;
        dly_q[c]  <= '0;
        run_q[c]  <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      win_q   <= win_d;
      att_q   <= att_d;
      ret_q   <= ret_d;
      hit_q   <= hit_d;
      vld_q   <= vld_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      pp_q    <= pp_d;
      meas_q  <= meas_d;
      ref_q   <= ref_d;
      dly_q   <= dly_d;
      run_q   <= run_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dly
    assign delay_out[g*DELAY_W +: DELAY_W] = dly_q[g];
  end

  assign impulse_start_out = (state_q == S_FIRE);
  assign busy_out          = (state_q != S_IDLE);
  assign done_out          = done_q;
  assign fail_out          = fail_q;
  assign delay_valid_out   = vld_q;

endmodule

// File: tb/tb_sos_multi_dist_calc.sv
`timescale 1ns/1ps
module tb_sos_multi_dist_calc;

  typedef struct {
    int         dut;
    int         id;
    int         d0;
    int         d1;
    logic [1:0] vld;
    logic       fail;
    int         np;
    int         kexp;
  } exp_t;

  logic        clk = 1'b0;
  logic        step = 1'b0;
  logic        rst [2];
  logic        trig [2];
  logic        imp_done [2];
  logic        man_done [2];
  logic [31:0] mic [2];
  logic        imp_start_w [2];
  logic [23:0] dly_w [2];
  logic [1:0]  vld_w [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        fail_w [2];

  int   mode [2]   = '{0, 0};
  int   pulses [2] = '{0, 0};
  int   k_tb [2]   = '{0, 0};
  int   burst3 [5] = '{100, 117, 100, 100, 100};
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ndone    = 0;
  int   cyc      = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  // Unit A: two channels, long listen window, plenty of attempts.
  sos_multi_dist_calc #(.NUM_CH(2), .RETRY_CYCLES(10)) dut_a (
    .clk_in(clk), .rst_in(rst[0]), .step_in(step), .trigger_in(trig[0]),
    .mic_in(mic[0]), .impulse_start_out(imp_start_w[0]), .impulse_done_in(imp_done[0]),
    .delay_out(dly_w[0]), .delay_valid_out(vld_w[0]), .busy_out(busy_w[0]),
    .done_out(done_w[0]), .fail_out(fail_w[0]));

  // Unit B: short listen window, four attempts, no energy floor.
  sos_multi_dist_calc #(.NUM_CH(2), .RETRY_CYCLES(10), .MAX_ATTEMPTS(4), .MAX_DELAY(64),
                        .MIN_ENERGY(0)) dut_b (
    .clk_in(clk), .rst_in(rst[1]), .step_in(step), .trigger_in(trig[1]),
    .mic_in(mic[1]), .impulse_start_out(imp_start_w[1]), .impulse_done_in(imp_done[1]),
    .delay_out(dly_w[1]), .delay_valid_out(vld_w[1]), .busy_out(busy_w[1]),
    .done_out(done_w[1]), .fail_out(fail_w[1]));

  function automatic logic [15:0] samp(input int m, input int ch, input int att, input int k);
    int pos;
    pos = -1;
    case (m)
      1: pos = 100;
      2: pos = (ch == 0) ? 100 : 200;
      3: pos = (ch == 1 || att < 0 || att > 4) ? 100 : burst3[att];
      4: pos = -2;
      default: pos = -1;
    endcase
    if (pos == -2) return (ch == 0) ? 16'h8000 : 16'h0000;
    if (pos >= 0 && k >= pos && k < pos + 32) return (k % 2 == 1) ? 16'hE0C0 : 16'h1F40;
    return 16'h0000;
  endfunction

  assign mic[0] = {samp(mode[0], 1, pulses[0] - 1, k_tb[0]), samp(mode[0], 0, pulses[0] - 1, k_tb[0])};
  assign mic[1] = {samp(mode[1], 1, pulses[1] - 1, k_tb[1]), samp(mode[1], 0, pulses[1] - 1, k_tb[1])};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample index seen by each unit: 0 at impulse_done, +1 per processed strobe.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (imp_done[d])  k_tb[d] <= 0;
      else if (step)    k_tb[d] <= k_tb[d] + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      step = (cyc % 4 == 0);
    end
  end

  // Impulse generator model and scoreboard consumer.
  initial begin
    int   dcnt [2];
    exp_t e;
    dcnt = '{0, 0};
    imp_done[0] = 1'b0;
    imp_done[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (imp_start_w[d]) begin
          pulses[d]++;
          dcnt[d] = 4;
        end else if (dcnt[d] != 0) begin
          dcnt[d]--;
        end
        imp_done[d] = (dcnt[d] == 1) || man_done[d];
        if (done_w[d]) begin
          if (sb.size() != 0 && sb[0].dut == d) begin
            e = sb.pop_front();
            check($sformatf("t%0d_valid", e.id), 32'(vld_w[d]), 32'(e.vld));
            if (e.vld[0]) check($sformatf("t%0d_delay0", e.id), 32'(dly_w[d][11:0]), e.d0);
            if (e.vld[1]) check($sformatf("t%0d_delay1", e.id), 32'(dly_w[d][23:12]), e.d1);
            check($sformatf("t%0d_fail", e.id), 32'(fail_w[d]), 32'(e.fail));
            check($sformatf("t%0d_pulses", e.id), pulses[d], e.np);
            if (e.kexp >= 0) check($sformatf("t%0d_listen_len", e.id), k_tb[d], e.kexp);
            ndone++;
          end else begin
            check($sformatf("spurious_done_u%0d", d), 32'(done_w[d]), 32'd0);
          end
        end
      end
    end
  end

  task automatic check_idle(input int d, input string tag);
    check({tag, "_imp_start"}, 32'(imp_start_w[d]), 32'd0);
    check({tag, "_busy"},      32'(busy_w[d]),      32'd0);
    check({tag, "_done"},      32'(done_w[d]),      32'd0);
    check({tag, "_fail"},      32'(fail_w[d]),      32'd0);
    check({tag, "_valid"},     32'(vld_w[d]),       32'd0);
    check({tag, "_delay"},     32'(dly_w[d]),       32'd0);
  endtask

  task automatic run_case(input int d, input int m, input int id, input int d0, input int d1,
                          input logic [1:0] v, input logic f, input int np, input int kexp,
                          input bit retrig);
    exp_t e;
    int   target;
    int   cnt;
    e.dut = d; e.id = id; e.d0 = d0; e.d1 = d1; e.vld = v; e.fail = f; e.np = np; e.kexp = kexp;
    mode[d]   = m;
    pulses[d] = 0;
    target    = ndone + 1;
    sb.push_back(e);
    trig[d] = 1'b1;
    @(negedge clk);
    trig[d] = 1'b0;
    check($sformatf("t%0d_busy_after_trig", id), 32'(busy_w[d]), 32'd1);
    check($sformatf("t%0d_valid_cleared", id),   32'(vld_w[d]),  32'd0);
    check($sformatf("t%0d_fail_cleared", id),    32'(fail_w[d]), 32'd0);
    cnt = 0;
    while (ndone < target && cnt < 20000) begin
      @(negedge clk);
      cnt++;
      trig[d] = (retrig && cnt == 200);
    end
    trig[d] = 1'b0;
    if (ndone < target) begin
      check($sformatf("t%0d_timeout", id), ndone, target);
      sb.delete();
    end
    repeat (3) @(negedge clk);
    check($sformatf("t%0d_idle_after", id), 32'(busy_w[d]), 32'd0);
  endtask

  initial begin
    int cnt;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; trig[d] = 1'b0; man_done[d] = 1'b0;
    end
    repeat (5) @(negedge clk);
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Bursts at 100 on both channels: onset in window 6, start 96.
    run_case(0, 1, 1, 96, 96, 2'b11, 1'b0, 3, -1, 1'b0);
    // Channels at 100 and 200, with a trigger during the run that must be ignored.
    run_case(0, 2, 2, 96, 192, 2'b11, 1'b0, 3, -1, 1'b1);
    // ch0 at 100,117,100,100,100: the run restarts twice, confirmed after attempt 5.
    run_case(0, 3, 3, 96, 96, 2'b11, 1'b0, 5, -1, 1'b0);
    // Silence: every listen ends after 64 strobes, four attempts, then fail.
    run_case(1, 0, 4, 0, 0, 2'b00, 1'b1, 4, 64, 1'b0);
    // Constant full-scale negative input: window sums stay equal, never an onset.
    run_case(1, 4, 5, 0, 0, 2'b00, 1'b1, 4, 64, 1'b0);

    // Reset during listen, then a stray impulse_done.
    mode[0]   = 1;
    pulses[0] = 0;
    trig[0]   = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    cnt = 0;
    while (!imp_done[0] && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_impulse_seen", 32'(imp_done[0]), 32'd1);
    repeat (100) @(negedge clk);
    check("rst_busy_in_listen", 32'(busy_w[0]), 32'd1);
    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    check_idle(0, "rst_mid");
    man_done[0] = 1'b1;
    repeat (2) @(negedge clk);
    man_done[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_no_refire", pulses[0], 1);
    check_idle(0, "rst_after_stray");

    // Normal operation resumes after the abort.
    run_case(0, 1, 7, 96, 96, 2'b11, 1'b0, 3, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sos_multi_dist_calc.md
Name: sos_multi_dist_calc

Overview:
- Parametrised successor to the single-channel speed-of-sound ranger: fires one impulse request and measures echo delay on NUM_CH microphones at once.
- Uses windowed-energy transient detection per channel.
- Reports a per-channel delay only after CONFIRM_COUNT consecutive attempts agree within TOL.
- Sits between the impulse generator (external, handshaked) and the position/calibration logic, on the 24 kHz step_in sample strobe.

Parameters:
NUM_CH, 2, number of mic channels
WINDOW_SIZE, 16, samples per energy window (power of 2, >=2)
MAX_DELAY, 512, listen timeout in samples (< 2**DELAY_W)
DELAY_W, 12, width of delay results
THRESH_SHIFT, 1, onset needs cur > pp + (pp >> THRESH_SHIFT), i.e. 1.5x at 1
MIN_ENERGY, 1024, window sum must also be >= this
CONFIRM_COUNT, 3, consecutive agreeing attempts for validity
TOL, 1, allowed |delay - run reference| in samples
RETRY_CYCLES, 60_000_000, clk cycles idle between attempts
MAX_ATTEMPTS, 16, attempts before giving up

Ports:
clk_in  in  1  system clock
rst_in  in  1  sync active-high reset
step_in  in  1  one-cycle 24 kHz sample strobe
trigger_in  in  1  start measurement (honoured only in IDLE)
mic_in  in  16*NUM_CH  signed samples, channel c at [16c+15:16c]
impulse_start_out  out  1  one-cycle pulse requesting impulse
impulse_done_in  in  1  impulse emitted; time zero
delay_out  out  DELAY_W*NUM_CH  confirmed delay per channel, samples
delay_valid_out  out  NUM_CH  per-channel confirmed flag
busy_out  out  1  high outside IDLE
done_out  out  1  one-cycle pulse at end of measurement
fail_out  out  1  high when last measurement hit MAX_ATTEMPTS; cleared on trigger

Behaviour:
- Reset state:
  - all outputs 0; state IDLE; counters, window sums, run lengths 0.
  - Reset mid-operation aborts immediately; a later impulse_done_in is ignored.
- FSM: IDLE -> FIRE -> WAIT_IMP -> LISTEN -> EVAL -> {DONE, RETRY, IDLE}.
- IDLE:
  - trigger_in clears delay_valid_out, fail_out, all run lengths, and attempt count.
  - Next state FIRE.
- FIRE: impulse_start_out=1 for exactly one cycle; attempt count += 1; -> WAIT_IMP.
- WAIT_IMP:
  - On impulse_done_in: sample index k=0.
  - Per channel: window sum 0, window idx 0, prev and pp = all-ones, hit flag 0.
  - -> LISTEN. No timeout in this state.
- LISTEN, on each step_in, per channel:
  - Compute |x|, saturating: -32768 -> 32767.
  - Accumulate into cur, which is 16+log2(WINDOW_SIZE) bits, no overflow.
  - k increments every step.
  - On the last sample of a window, for a channel not yet hit:
    - Onset if cur > prev AND cur > pp + (pp >> THRESH_SHIFT) AND cur >= MIN_ENERGY. Compare in 1-bit-wider arithmetic.
    - On onset: hit=1 and meas = k - (WINDOW_SIZE-1), the first sample index of the detecting window.
    - Either way, shift the history: pp <- prev, prev <- cur, cur <- 0.
  - Exit to EVAL when all channels hit, or when k reaches MAX_DELAY (the sample at k=MAX_DELAY-1 is the last processed).
  - step_in is ignored outside LISTEN.
- EVAL (1 cycle), per channel:
  - A miss sets run=0.
  - A hit with run==0, or |meas - ref| > TOL: ref <- meas, run <- 1.
  - Otherwise run += 1; if the new run == CONFIRM_COUNT: delay_out[c] <- ref and delay_valid_out[c] <- 1. The flag stays set for the rest of the measurement; later disagreements do not clear it.
  - Then:
    - all valid -> DONE;
    - else if attempts == MAX_ATTEMPTS -> fail_out=1, done_out pulse, -> IDLE;
    - else -> RETRY.
  - CONFIRM_COUNT=1 validates on the first hit.
- RETRY: count RETRY_CYCLES clk cycles, then -> FIRE.
- DONE: done_out=1 for one cycle -> IDLE.
- busy_out = (state != IDLE).
- trigger_in while busy is ignored.
- impulse_done_in outside WAIT_IMP is ignored.

Test Plan:
- NUM_CH=1, RETRY_CYCLES=10. Trigger; mic silent except ±8000 at samples 100-131 on every attempt. Expected:
  - exactly 3 impulse_start_out pulses;
  - delay_out=96 (window 6 start), delay_valid_out=1;
  - done_out pulse; fail_out=0.
- NUM_CH=2. ch0 burst at 100, ch1 burst at 200, repeated. Expected: delays 96 and 192, both valid at the same EVAL, one done_out.
- Burst position per attempt 100, 117, 100, 100, 100 (WINDOW_SIZE=16, TOL=1). Expected: the run restarts at attempt 2 and 3; valid after attempt 5 with delay 96; 5 impulse pulses.
- Silent mic, MAX_ATTEMPTS=4, MAX_DELAY=64. Expected:
  - each LISTEN lasts exactly 64 steps;
  - 4 impulse pulses; fail_out=1; done_out pulse; delay_valid_out=0.
- Constant -32768 input on ch0 with MIN_ENERGY=0. Expected: window sum 16*32767 with no wrap; no onset after the first two windows, because cur equals prev.
- Assert rst_in during LISTEN, then pulse impulse_done_in. Expected: state IDLE, all outputs 0, no impulse_start_out until a new trigger_in.
